// File: rtl/shift_arbiter.sv
// shift_arbiter: two requesters share one barrel shifter; the result is held
// in a single output register until the consumer takes it.
module shift_arbiter #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rstb,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [1:0]   req0_op,
    input  logic [N-1:0] req0_a,
    input  logic [N-1:0] req0_b,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [1:0]   req1_op,
    input  logic [N-1:0] req1_a,
    input  logic [N-1:0] req1_b,
    output logic         resp_valid,
    input  logic         resp_ready,
    output logic         resp_id,
    output logic [N-1:0] resp_data,
    output logic [15:0]  ops_done
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] HOLD = 1'b1;

    localparam logic [1:0] OP_SLL  = 2'b00;
    localparam logic [1:0] OP_SRL  = 2'b01;
    localparam logic [1:0] OP_SRA  = 2'b10;

    localparam int unsigned SW = $clog2(N);
    localparam logic [N-1:0] N_W = N;

    logic [0:0]   state_q, state_d;
    logic         rr_q, rr_d;
    logic         id_q, id_d;
    logic [N-1:0] data_q, data_d;
    logic [15:0]  ops_q, ops_d;

    logic         slot_free;
    logic         grant;
    logic         accept;
    logic [1:0]   sel_op;
    logic [N-1:0] sel_a;
    logic [N-1:0] sel_b;
    logic [N-1:0] shift_res;
    logic [SW-1:0] sh;
    logic         big;

    // Arbitration: a lone requester wins outright, a tie goes to the rr pointer.
    always_comb begin
        slot_free = (state_q == IDLE) | resp_ready;
        if (req0_valid && !req1_valid) begin
            grant = 1'b0;
        end else if (req1_valid && !req0_valid) begin
            grant = 1'b1;
        end else begin
            grant = rr_q;
        end
        req0_ready = slot_free & req0_valid & (grant == 1'b0);
        req1_ready = slot_free & req1_valid & (grant == 1'b1);
        accept     = req0_ready | req1_ready;
    end

    // Shared shifter: operands come only from the granted requester.
    always_comb begin
        sel_op = grant ? req1_op : req0_op;
        sel_a  = grant ? req1_a  : req0_a;
        sel_b  = grant ? req1_b  : req0_b;
        // Any amount >= N saturates; below that only the low bits matter.
        big    = (sel_b >= N_W);
        sh     = sel_b[SW-1:0];
        case (sel_op)
            OP_SLL:  shift_res = big ? '0 : (sel_a << sh);
            OP_SRL:  shift_res = big ? '0 : (sel_a >> sh);
            OP_SRA:  shift_res = big ? {N{sel_a[N-1]}}
                                     : $unsigned($signed(sel_a) >>> sh);
            default: shift_res = sel_a;
        endcase
    end

    // Next-state: output register, pointer, FSM and saturating transfer count.
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        id_d    = id_q;
        data_d  = data_q;
        ops_d   = ops_q;
        if (accept) begin
            state_d = HOLD;
            rr_d    = ~grant;
            id_d    = grant;
            data_d  = shift_res;
        end else if (state_q == HOLD && resp_ready) begin
            state_d = IDLE;
        end
        if (state_q == HOLD && resp_ready && ops_q != 16'hFFFF) begin
            ops_d = ops_q + 16'd1;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q <= IDLE;
            rr_q    <= 1'b0;
            id_q    <= 1'b0;
            data_q  <= '0;
            ops_q   <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            id_q    <= id_d;
            data_q  <= data_d;
            ops_q   <= ops_d;
        end
    end

    assign resp_valid = (state_q == HOLD);
    assign resp_id    = id_q;
    assign resp_data  = data_q;
    assign ops_done   = ops_q;

endmodule
